// File: rtl/fifo_read_arbiter_if.sv
// Read-port bundle between the FIFO read arbiter and its consumers/RAM.
// The arbiter side uses the master modport.
interface fifo_read_arbiter_if #(
    parameter int unsigned ADDRESS_SIZE = 4,
    parameter int unsigned NUM_REQ      = 4
);
    logic [ADDRESS_SIZE:0]   rwptr_sync;
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      gnt;
    logic                    rinc;
    logic [ADDRESS_SIZE-1:0] raddr;
    logic [ADDRESS_SIZE:0]   rptr;
    logic                    rempty;
    logic [ADDRESS_SIZE:0]   rfill;
    logic                    rvalid;
    logic [NUM_REQ-1:0]      rvalid_id;

    modport master (
        input  rwptr_sync, req,
        output gnt, rinc, raddr, rptr, rempty, rfill, rvalid, rvalid_id
    );

    modport slave (
        output rwptr_sync, req,
        input  gnt, rinc, raddr, rptr, rempty, rfill, rvalid, rvalid_id
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Read-domain controller of the dual-clock FIFO: round-robin, burst-bounded
// sharing of the read port, read pointer ownership, empty flag and fill level.
module fifo_read_arbiter #(
    parameter int unsigned ADDRESS_SIZE = 4,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic                 rclk,
    input  logic                 rreset,
    fifo_read_arbiter_if.master  bus
);
    localparam int unsigned PW = ADDRESS_SIZE + 1;
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      last_owner_q, last_owner_d;
    logic [CW-1:0]      count_q, count_d;
    logic [IW-1:0]      winner;
    logic               winner_found;
    int unsigned        cand;
    logic               idle_go, burst_go;
    logic [NUM_REQ-1:0] gnt;
    logic               rinc;

    logic [PW-1:0]      rbin_q, rbin_d, rgray_d, rptr_q, rfill_q, rwbin;
    logic               rempty_q, rvalid_q;
    logic [NUM_REQ-1:0] rvalid_id_q;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int unsigned k = 1; k < PW; k++) b = b ^ (g >> k);
        return b;
    endfunction

    // Circular search for the first requester after the last owner
    always_comb begin
        winner       = last_owner_q;
        winner_found = 1'b0;
        cand         = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(last_owner_q) + i) % NUM_REQ;
            if (!winner_found && bus.req[IW'(cand)]) begin
                winner       = IW'(cand);
                winner_found = 1'b1;
            end
        end
    end

    assign idle_go  = !rempty_q && winner_found;
    assign burst_go = bus.req[owner_q] && !rempty_q && (count_q < CW'(MAX_BURST));

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IW'(NUM_REQ - 1);
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
        end
    end

    // Release from BURST always passes through IDLE, giving one bubble cycle
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        count_d      = count_q;
        case (state_q)
            IDLE: begin
                if (idle_go) begin
                    state_d = BURST;
                    owner_d = winner;
                    count_d = CW'(1);
                end
            end
            BURST: begin
                if (burst_go) begin
                    count_d = count_q + CW'(1);
                end else begin
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (!rreset) begin
            case (state_q)
                IDLE:    if (idle_go)  gnt[winner]  = 1'b1;
                BURST:   if (burst_go) gnt[owner_q] = 1'b1;
                default: gnt = '0;
            endcase
        end
    end

    assign rinc    = |gnt;
    assign rbin_d  = rbin_q + PW'(rinc);
    assign rgray_d = (rbin_d >> 1) ^ rbin_d;
    assign rwbin   = gray2bin(bus.rwptr_sync);

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            rbin_q      <= '0;
            rptr_q      <= '0;
            rempty_q    <= 1'b1;
            rfill_q     <= '0;
            rvalid_q    <= 1'b0;
            rvalid_id_q <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_q      <= rgray_d;
            rempty_q    <= (rgray_d == bus.rwptr_sync);
            rfill_q     <= rwbin - rbin_d;
            rvalid_q    <= rinc;
            rvalid_id_q <= gnt;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rinc      = rinc;
    assign bus.raddr     = rbin_q[ADDRESS_SIZE-1:0];
    assign bus.rptr      = rptr_q;
    assign bus.rempty    = rempty_q;
    assign bus.rfill     = rfill_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rvalid_id = rvalid_id_q;
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: reset, drain, round-robin bursts,
// early release, pointer wrap and reset during a burst.
module tb_fifo_read_arbiter;
    logic rclk;
    logic rreset;
    int   checks;
    int   errors;
    int   reads;
    int   w;

    fifo_read_arbiter_if #(.ADDRESS_SIZE(4), .NUM_REQ(4)) bus ();

    fifo_read_arbiter #(.ADDRESS_SIZE(4), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .rclk   (rclk),
        .rreset (rreset),
        .bus    (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Assert reset for one edge, check cleared state, release at posedge+1
    task automatic do_reset(input string tag);
        rreset = 1'b1;
        #1;
        check({tag, "_rst_gnt"},    32'(bus.gnt), 0);
        check({tag, "_rst_rinc"},   32'(bus.rinc), 0);
        check({tag, "_rst_rempty"}, 32'(bus.rempty), 1);
        check({tag, "_rst_rptr"},   32'(bus.rptr), 0);
        check({tag, "_rst_rfill"},  32'(bus.rfill), 0);
        check({tag, "_rst_rvalid"}, 32'(bus.rvalid), 0);
        tick();
        rreset = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        logic [3:0] prev_gnt;
        checks = 0;
        errors = 0;
        rreset = 1'b0;
        bus.req = '0;
        bus.rwptr_sync = '0;
        #6;

        // Drain three entries with a single requester
        do_reset("s1");
        bus.rwptr_sync = 5'b00010;
        bus.req = 4'b0001;
        #1 check("s2_stale_empty_gnt", 32'(bus.gnt), 0);
        tick();
        check("s2_c1_gnt", 32'(bus.gnt), 'b0001);
        check("s2_c1_raddr", 32'(bus.raddr), 0);
        check("s2_c1_rempty", 32'(bus.rempty), 0);
        check("s2_c1_rfill", 32'(bus.rfill), 3);
        tick();
        check("s2_c2_gnt", 32'(bus.gnt), 'b0001);
        check("s2_c2_raddr", 32'(bus.raddr), 1);
        check("s2_c2_rvalid", 32'(bus.rvalid), 1);
        check("s2_c2_rvalid_id", 32'(bus.rvalid_id), 'b0001);
        check("s2_c2_rptr", 32'(bus.rptr), 'b00001);
        check("s2_c2_rfill", 32'(bus.rfill), 2);
        tick();
        check("s2_c3_gnt", 32'(bus.gnt), 'b0001);
        check("s2_c3_raddr", 32'(bus.raddr), 2);
        check("s2_c3_rfill", 32'(bus.rfill), 1);
        tick();
        check("s2_c4_gnt", 32'(bus.gnt), 0);
        check("s2_c4_rempty", 32'(bus.rempty), 1);
        check("s2_c4_rptr", 32'(bus.rptr), 'b00010);
        check("s2_c4_rfill", 32'(bus.rfill), 0);
        check("s2_c4_rvalid", 32'(bus.rvalid), 1);
        tick();
        check("s2_c5_rvalid", 32'(bus.rvalid), 0);
        check("s2_c5_rvalid_id", 32'(bus.rvalid_id), 0);

        // Full FIFO, all four requesting: 4-read bursts separated by bubbles
        bus.req = 4'b1111;
        bus.rwptr_sync = 5'b11000;
        do_reset("s3");
        #1 check("s3_prime_gnt", 32'(bus.gnt), 0);
        tick();
        check("s3_rfill_full", 32'(bus.rfill), 16);
        check("s3_rempty0", 32'(bus.rempty), 0);
        prev_gnt = '0;
        for (int k = 0; k < 19; k++) begin
            exp_gnt = ((k % 5) == 4) ? 4'b0000 : 4'(1 << (k / 5));
            check($sformatf("s3_k%0d_gnt", k), 32'(bus.gnt), 32'(exp_gnt));
            if (exp_gnt != 4'b0000)
                check($sformatf("s3_k%0d_raddr", k), 32'(bus.raddr), (k / 5) * 4 + (k % 5));
            if (k > 0)
                check($sformatf("s3_k%0d_rvalid_id", k), 32'(bus.rvalid_id), 32'(prev_gnt));
            prev_gnt = exp_gnt;
            tick();
        end
        check("s3_end_gnt", 32'(bus.gnt), 0);
        check("s3_end_rempty", 32'(bus.rempty), 1);
        check("s3_end_rfill", 32'(bus.rfill), 0);
        check("s3_end_rptr", 32'(bus.rptr), 'b11000);

        // Requester 2 drops req after two reads; requester 3 is next
        bus.req = 4'b1100;
        bus.rwptr_sync = 5'b11000;
        do_reset("s4");
        #1 check("s4_prime_gnt", 32'(bus.gnt), 0);
        tick();
        check("s4_r1_gnt", 32'(bus.gnt), 'b0100);
        check("s4_r1_raddr", 32'(bus.raddr), 0);
        tick();
        check("s4_r2_gnt", 32'(bus.gnt), 'b0100);
        check("s4_r2_raddr", 32'(bus.raddr), 1);
        tick();
        bus.req = 4'b1000;
        #1 check("s4_bubble_gnt", 32'(bus.gnt), 0);
        tick();
        check("s4_next_gnt", 32'(bus.gnt), 'b1000);
        check("s4_next_raddr", 32'(bus.raddr), 2);

        // 40 writes in steps of 5; read pointer wraps past 31
        bus.req = 4'b0001;
        bus.rwptr_sync = '0;
        do_reset("s5");
        reads = 0;
        for (int step = 1; step <= 8; step++) begin
            w = step * 5;
            bus.rwptr_sync = b2g(5'(w));
            #1 check($sformatf("s5_w%0d_stale_gnt", w), 32'(bus.gnt), 0);
            tick();
            check($sformatf("s5_w%0d_rempty0", w), 32'(bus.rempty), 0);
            check($sformatf("s5_w%0d_rfill", w), 32'(bus.rfill), 5);
            for (int c = 0; c < 12; c++) begin
                if (bus.gnt != 4'b0000) begin
                    check($sformatf("s5_w%0d_gnt", w), 32'(bus.gnt), 'b0001);
                    check($sformatf("s5_w%0d_raddr", w), 32'(bus.raddr), reads % 16);
                    reads++;
                end
                tick();
            end
            check($sformatf("s5_w%0d_reads", w), 32'(reads), w);
            check($sformatf("s5_w%0d_rptr", w), 32'(bus.rptr), 32'(b2g(5'(w))));
            check($sformatf("s5_w%0d_rempty1", w), 32'(bus.rempty), 1);
            check($sformatf("s5_w%0d_rfill0", w), 32'(bus.rfill), 0);
        end

        // Reset asserted in the second cycle of a burst
        bus.req = 4'b0001;
        bus.rwptr_sync = 5'b11000;
        do_reset("s6");
        tick();
        check("s6_c1_gnt", 32'(bus.gnt), 'b0001);
        tick();
        check("s6_c2_gnt", 32'(bus.gnt), 'b0001);
        check("s6_c2_rvalid", 32'(bus.rvalid), 1);
        rreset = 1'b1;
        #1;
        check("s6_mid_gnt", 32'(bus.gnt), 0);
        check("s6_mid_rinc", 32'(bus.rinc), 0);
        check("s6_mid_rvalid", 32'(bus.rvalid), 0);
        check("s6_mid_rempty", 32'(bus.rempty), 1);
        check("s6_mid_rptr", 32'(bus.rptr), 0);
        check("s6_mid_rfill", 32'(bus.rfill), 0);
        tick();
        check("s6_suppressed_rvalid", 32'(bus.rvalid), 0);
        bus.req = 4'b1111;
        rreset = 1'b0;
        #1 check("s6_post_prime_gnt", 32'(bus.gnt), 0);
        tick();
        check("s6_post_gnt", 32'(bus.gnt), 'b0001);
        check("s6_post_raddr", 32'(bus.raddr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
